// File: rtl/mult_stream_adapter_if.sv
// Signal bundle joining the mult stream adapter to its operand producer,
// its result consumer and the two-cycle Mult stage.
interface mult_stream_adapter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_left;
  logic [31:0] in_right;
  logic        mul_go;
  logic [31:0] mul_left;
  logic [31:0] mul_right;
  logic [31:0] mul_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_left, in_right, mul_out, out_ready,
    output in_ready, mul_go, mul_left, mul_right, out_valid, out_data
  );

  modport master (
    output in_valid, in_left, in_right, mul_out, out_ready,
    input  in_ready, mul_go, mul_left, mul_right, out_valid, out_data
  );
endinterface

// File: rtl/mult_stream_adapter.sv
// Valid/ready front end for the two-cycle Mult stage: issues a go pulse with held
// operands, captures the product two cycles later and queues it in a credit-guarded FIFO.
module mult_stream_adapter #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_stream_adapter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          s_go_r;
  logic          s_1_r;
  logic          s_2_r;
  logic [31:0]   left_r;
  logic [31:0]   right_r;
  logic          in_ready_r;

  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   mem_r [DEPTH];
  logic          out_valid_r;
  logic [31:0]   out_data_r;

  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          in_ready_next_s;
  logic [AW-1:0] rd_ptr_next_s;
  logic [AW-1:0] wr_ptr_next_s;
  logic [CW-1:0] count_next_s;
  logic [CW:0]   credit_sum_s;
  logic [31:0]   head_next_s;

  // Handshake decode plus next-state of FIFO bookkeeping, credit and head data
  always_comb begin
    accept_s = bus.in_valid && in_ready_r;
    push_s   = s_2_r;
    pop_s    = out_valid_r && bus.out_ready;

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase

    // Ready is computed from next-cycle state so the port comes straight from a flop;
    // the pop term only reaches it through count, never combinationally.
    credit_sum_s = {1'b0, count_next_s} + (CW+1)'(accept_s)
                 + (CW+1)'(s_go_r) + (CW+1)'(s_1_r);
    if (!accept_s && (credit_sum_s < (CW+1)'(DEPTH))) begin
      in_ready_next_s = 1'b1;
    end else begin
      in_ready_next_s = 1'b0;
    end

    // A capture landing on the next head slot bypasses the array
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = bus.mul_out;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Issue pipeline, operand hold registers and the input ready flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_go_r     <= 1'b0;
      s_1_r      <= 1'b0;
      s_2_r      <= 1'b0;
      left_r     <= 32'd0;
      right_r    <= 32'd0;
      in_ready_r <= 1'b1;
    end else begin
      s_go_r     <= accept_s;
      s_1_r      <= s_go_r;
      s_2_r      <= s_1_r;
      in_ready_r <= in_ready_next_s;
      if (accept_s) begin
        left_r  <= bus.in_left;
        right_r <= bus.in_right;
      end
    end
  end

  // Result FIFO storage, pointers, occupancy and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      rd_ptr_r    <= rd_ptr_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != {CW{1'b0}});
      out_data_r  <= head_next_s;
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.mul_out;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mul_go    = s_go_r;
  assign bus.mul_left  = left_r;
  assign bus.mul_right = right_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_mult_stream_adapter.sv
// Self-checking bench for mult_stream_adapter with a behavioural two-cycle multiplier
// and a queue-based scoreboard of expected products.
module tb_mult_stream_adapter;
  localparam int DEPTH = 4;

  logic clk;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mult_stream_adapter_if bus ();

  mult_stream_adapter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] low_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Mult stand-in: uses operands in T+1, result visible only in T+2, garbage otherwise
  logic        go_d;
  logic [31:0] mult_hold;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_d      <= 1'b0;
      mult_hold <= 32'd0;
    end else begin
      go_d      <= bus.mul_go;
      mult_hold <= go_d ? low_product(bus.mul_left, bus.mul_right) : 32'hDEAD_BEEF;
    end
  end
  assign bus.mul_out = mult_hold;

  // Scoreboard: every accepted pair owes one product, delivered in order
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] want_q[$];
  int          pop_cyc_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(low_product(bus.in_left, bus.in_right));
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
        else want_q.push_back(32'hxxxx_xxxx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [31:0] l, input logic [31:0] r, input logic rdy);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_left   = l;
    bus.in_right  = r;
    bus.out_ready = rdy;
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input logic rdy,
                           output logic ok, output int acc);
    ok  = 1'b0;
    acc = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      drive(1'b1, l, r, rdy);
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    want_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_left = 32'd0; bus.in_right = 32'd0; bus.out_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.mul_go !== 1'b0) begin n_bad++; $display("FAIL reset_mul_go: got %b want 0", bus.mul_go); end
    n_cmp++; if (bus.mul_left !== 32'd0) begin n_bad++; $display("FAIL reset_mul_left: got %h want 0", bus.mul_left); end
    n_cmp++; if (bus.mul_right !== 32'd0) begin n_bad++; $display("FAIL reset_mul_right: got %h want 0", bus.mul_right); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic ok;
    int   a;
    logic seen;
    clear_logs();
    send_pair(32'd3, 32'd5, 1'b0, ok, a);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", ok); end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.mul_go !== 1'b1) begin n_bad++; $display("FAIL single_go_T: got %b want 1", bus.mul_go); end
    n_cmp++; if (bus.mul_left !== 32'd3) begin n_bad++; $display("FAIL single_left_T: got %h want 3", bus.mul_left); end
    n_cmp++; if (bus.mul_right !== 32'd5) begin n_bad++; $display("FAIL single_right_T: got %h want 5", bus.mul_right); end
    @(negedge clk);
    n_cmp++; if (bus.mul_go !== 1'b0) begin n_bad++; $display("FAIL single_go_T1: got %b want 0", bus.mul_go); end
    n_cmp++; if (bus.mul_left !== 32'd3) begin n_bad++; $display("FAIL single_left_T1: got %h want 3", bus.mul_left); end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL single_timeout: out_valid never rose");
    end else begin
      n_cmp++; if (cyc - a !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", cyc - a); end
      n_cmp++; if (bus.out_data !== 32'd15) begin n_bad++; $display("FAIL single_data: got %0d want 15", bus.out_data); end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b want 0", bus.out_valid); end
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_stream();
    int i;
    int k;
    clear_logs();
    i = 1;
    k = 0;
    while (i <= 8 && k < 40) begin
      drive(1'b1, 32'(i), 32'(i + 1), 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== ((k % 2) == 0)) begin
        n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want %b", k, bus.in_ready, (k % 2) == 0);
      end
      if (bus.in_ready === 1'b1) i++;
      k++;
    end
    for (int w = 0; w < 30 && got_q.size() < 8; w++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
    end
    n_cmp++; if (got_q.size() !== 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < 8; j++) begin
      n_cmp++;
      if (got_q[j] !== 32'((j + 1) * (j + 2))) begin
        n_bad++; $display("FAIL stream_data[%0d]: got %0d want %0d", j, got_q[j], (j + 1) * (j + 2));
      end
      if (j > 0) begin
        n_cmp++;
        if (pop_cyc_q[j] - pop_cyc_q[j-1] !== 2) begin
          n_bad++; $display("FAIL stream_spacing[%0d]: got %0d want 2", j, pop_cyc_q[j] - pop_cyc_q[j-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lv[6];
    logic [31:0] rv[6];
    int   sent;
    logic popped;
    logic checked;
    clear_logs();
    for (int j = 0; j < 6; j++) begin
      lv[j] = $urandom;
      rv[j] = $urandom;
    end
    sent = 0;
    for (int k = 0; k < 24; k++) begin
      drive(sent < 6, lv[sent < 6 ? sent : 0], rv[sent < 6 ? sent : 0], 1'b0);
      @(negedge clk);
      if (k >= 10) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall[%0d]: got %b want 0", k, bus.in_ready); end
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    n_cmp++; if (sent !== DEPTH) begin n_bad++; $display("FAIL bp_accepted: got %0d want %0d", sent, DEPTH); end
    popped  = 1'b0;
    checked = 1'b0;
    for (int k = 0; k < 60 && got_q.size() < 6; k++) begin
      drive(sent < 6, lv[sent < 6 ? sent : 0], rv[sent < 6 ? sent : 0], 1'b1);
      @(negedge clk);
      if (popped && !checked) begin
        checked = 1'b1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) popped = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    n_cmp++; if (got_q.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < 6; j++) begin
      n_cmp++;
      if (got_q[j] !== low_product(lv[j], rv[j])) begin
        n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", j, got_q[j], low_product(lv[j], rv[j]));
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic ok;
    int   a;
    clear_logs();
    for (int j = 0; j < 3; j++) begin
      send_pair($urandom, $urandom, 1'b0, ok, a);
      drive(1'b0, 32'd0, 32'd0, 1'b0);
    end
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b0);
    send_pair(32'd11, 32'd13, 1'b0, ok, a);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL pp_accept4: got %b want 1", ok); end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL pp_one_pop: got %0d want 1", got_q.size()); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pp_still_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_count_kept: in_ready got %b want 1", bus.in_ready); end
    for (int k = 0; k < 20 && bus.out_valid === 1'b1; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL pp_total: got %0d want 4", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== want_q[j]) begin n_bad++; $display("FAIL pp_order[%0d]: got %h want %h", j, got_q[j], want_q[j]); end
    end
    n_cmp++;
    if (got_q.size() > 3 && got_q[3] !== 32'd143) begin n_bad++; $display("FAIL pp_last: got %0d want 143", got_q[3]); end
  endtask

  task automatic test_wrap_arith();
    logic ok;
    int   a;
    clear_logs();
    send_pair(32'hFFFF_FFFF, 32'd2, 1'b1, ok, a);
    send_pair(32'h0001_0000, 32'h0001_0000, 1'b1, ok, a);
    for (int k = 0; k < 20 && got_q.size() < 2; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
    end
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_cmp++; if (got_q[0] !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL wrap_ffff_x2: got %h want fffffffe", got_q[0]); end
      n_cmp++; if (got_q[1] !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_10000_sq: got %h want 0", got_q[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic ok;
    int   a;
    logic seen;
    clear_logs();
    send_pair(32'd7, 32'd9, 1'b1, ok, a);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mul_go !== 1'b0) begin n_bad++; $display("FAIL rst_go: got %b want 0", bus.mul_go); end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale_valid[%0d]: got %b want 0", k, bus.out_valid); end
      n_cmp++; if (bus.mul_go !== 1'b0) begin n_bad++; $display("FAIL rst_stale_go[%0d]: got %b want 0", k, bus.mul_go); end
    end
    send_pair(32'd2, 32'd4, 1'b1, ok, a);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL rst_timeout: out_valid never rose");
    end else begin
      n_cmp++; if (cyc - a !== 4) begin n_bad++; $display("FAIL rst_latency: got %0d want 4", cyc - a); end
      n_cmp++; if (bus.out_data !== 32'd8) begin n_bad++; $display("FAIL rst_data: got %0d want 8", bus.out_data); end
    end
    repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL rst_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] cl;
    logic [31:0] cr;
    int   sent;
    logic v;
    logic rdy;
    logic hold;
    logic [31:0] held;
    clear_logs();
    cl = $urandom; cr = $urandom;
    sent = 0;
    hold = 1'b0;
    held = 32'd0;
    for (int k = 0; k < 600 && (sent < 32 || got_q.size() < 32); k++) begin
      v   = (sent < 32) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      drive(v, cl, cr, rdy);
      @(negedge clk);
      if (hold) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
          n_bad++; $display("FAIL rand_head_stable[%0d]: got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, held);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        cl = $urandom; cr = $urandom;
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    n_cmp++; if (got_q.size() !== 32) begin n_bad++; $display("FAIL rand_count: got %0d want 32", got_q.size()); end
    for (int j = 0; j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j] !== want_q[j]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", j, got_q[j], want_q[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_push_pop_full();
    test_wrap_arith();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
